// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: initiator side of the LC-3 memory bus.
// Accepts one load/store request at a time. Addresses below IO_BASE go to RAM
// and wait for the R completion strobe, with a watchdog that forces an error
// completion. Addresses at or above IO_BASE take a single-cycle I/O access.
// Every completion is reported with a one-cycle resp_valid pulse.
module mem_access_ctrl #(
  parameter logic [15:0] IO_BASE = 16'hFE00,
  parameter int          TIMEOUT = 16
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic        req_valid,
  input  logic        req_rw,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        resp_err,
  output logic [15:0] MAR_OUT,
  output logic [15:0] MDR_OUT,
  output logic        RW,
  output logic        MEM_EN,
  output logic        MIO_EN,
  input  logic [15:0] MEM_OUT,
  input  logic        R,
  input  logic [15:0] IO_RDATA
);

  // Watchdog terminal count. The counter starts at 0 in the first WAIT_MEM
  // cycle, so MEM_EN is high for exactly TIMEOUT cycles when R never arrives.
  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    IO_ACC   = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t     state;
  logic [7:0] wd_cnt;

  // Access sequencer; all bus and response outputs are registered here.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state      <= IDLE;
      wd_cnt     <= 8'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 16'h0000;
      resp_err   <= 1'b0;
      MAR_OUT    <= 16'h0000;
      MDR_OUT    <= 16'h0000;
      RW         <= 1'b0;
      MEM_EN     <= 1'b0;
      MIO_EN     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            MAR_OUT   <= req_addr;
            MDR_OUT   <= req_wdata;
            RW        <= req_rw;
            req_ready <= 1'b0;
            wd_cnt    <= 8'd0;
            if (req_addr >= IO_BASE) begin
              MIO_EN <= 1'b1;
              state  <= IO_ACC;
            end else begin
              MEM_EN <= 1'b1;
              state  <= WAIT_MEM;
            end
          end
        end

        WAIT_MEM: begin
          wd_cnt <= wd_cnt + 8'd1;
          if (R) begin
            // A completion in the final watchdog cycle still counts as success.
            if (!RW) resp_rdata <= MEM_OUT;
            MEM_EN     <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            state      <= DONE;
          end else if (wd_cnt == LAST_CNT) begin
            if (!RW) resp_rdata <= 16'h0000;
            MEM_EN     <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            state      <= DONE;
          end
        end

        IO_ACC: begin
          // Writes need no capture: the I/O register loads from the decode.
          if (!RW) resp_rdata <= IO_RDATA;
          MIO_EN     <= 1'b0;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          state      <= DONE;
        end

        DONE: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          wd_cnt     <= 8'd0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end

        default: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          MEM_EN     <= 1'b0;
          MIO_EN     <= 1'b0;
          wd_cnt     <= 8'd0;
        end
      endcase
    end
  end

endmodule
